poke_restore_tx: RTL and testbench
==================================

// Module: poke_restore_tx
// PURPOSE
//  Transmit-side counterpart of the card-arrange stage. Takes a hand in internal
//  sort encoding and maps each card back to wire encoding: rank nibble F->2, E->1.
//  It then sends the hand card by card, one byte per transfer, over a valid/ready
//  handshake into the UART byte transmitter. Sits between the game logic and the UART TX.
// PARAMETERS
//  CARD_NUM  17  number of card slots in the hand
//  CARD_W    8   bits per card: [7:4] rank, [3:0] suit (fixed at 8; tx byte width)
// PORTS
//  sys_clk       in   1                  system clock, all logic on rising edge
//  sys_rst       in   1                  asynchronous reset, active-high
//  send_start    in   1                  1-cycle request to send the hand on arrange_poke
//  arrange_poke  in   CARD_NUM*CARD_W    hand in internal encoding; card i = [8i+7:8i]
//  tx_ready      in   1                  UART TX can accept tx_data this cycle
//  tx_data       out  8                  card byte in wire encoding
//  tx_valid      out  1                  tx_data valid; held until accepted
//  busy          out  1                  high from accepted send_start until send_done
//  send_done     out  1                  1-cycle pulse after last card handled
// BEHAVIOUR
//  - Reset (async, sys_rst=1): all outputs 0, state IDLE, index 0, snapshot cleared.
//    Reset mid-send abandons the hand; no further bytes are sent.
//  - FSM states: IDLE, LOAD, SEND, DONE.
//    IDLE: send_start=1 -> latch arrange_poke into snapshot, idx<=0, busy<=1, go LOAD.
//    LOAD: drive tx_data<=restore(card[idx]), tx_valid<=1, go SEND.
//    SEND: if tx_valid&&tx_ready -> transfer done. If idx==CARD_NUM-1: tx_valid<=0,
//      send_done<=1, go DONE. Else idx<=idx+1; tx_data<=next card the same cycle;
//      tx_valid stays 1.
//    DONE: send_done<=0, busy<=0, go IDLE.
//  - Handshake: while tx_valid=1 and tx_ready=0, tx_data and tx_valid hold stable.
//    Transfer happens only on a cycle with both high. Max throughput is 1 byte/cycle.
//  - Latency: first tx_valid rises 2 cycles after the send_start cycle.
//    Minimum hand time is CARD_NUM transfer cycles plus 3.
//  - send_start while busy (LOAD/SEND/DONE) is ignored and does not restart the send.
//    The snapshot isolates the send from later arrange_poke changes.
//  - restore(c): c[7:4]==F -> {4'h2,c[3:0]}; c[7:4]==E -> {4'h1,c[3:0]};
//    else c unchanged. Suit nibble is never modified.
//  - Send order: card 0 (bits [7:0]) first, card CARD_NUM-1 last.
//  - idx width is clog2(CARD_NUM); it never exceeds CARD_NUM-1 (no wrap).
// CONFIGURATION
//  SKIP_EMPTY_EN defined:
//   - A snapshot card equal to 8'h00 (played or empty slot) is not sent.
//   - Each skipped slot costs 1 cycle with tx_valid=0; idx advances.
//   - If the last slot is empty, send_done follows the skip cycle.
//   - An all-empty hand gives zero transfers, then send_done.
//  SKIP_EMPTY_EN undefined: 8'h00 is sent as 8'h00 like any other card
//   (restore leaves it unchanged), so exactly CARD_NUM bytes are always sent.
// TESTING
//  1. Hand card i = {4'h3+(i%10),4'h1}, tx_ready=1 always, one send_start:
//     -> 17 bytes on consecutive cycles, in order, unchanged; send_done once; busy falls after.
//  2. Cards 0..3 = F3,E2,D4,A1, tx_ready=1:
//     -> tx_data sequence starts 23,12,D4,A1 (F->2, E->1, others unchanged).
//  3. tx_ready toggles 1-in-3 cycles:
//     -> tx_data and tx_valid stable across every stall cycle; 17 transfers; no byte lost or repeated.
//  4. send_start pulsed again during SEND, and arrange_poke changed mid-send:
//     -> ignored; original snapshot bytes sent; exactly one send_done.
//  5. sys_rst=1 after the 5th transfer, then released, then a new send_start:
//     -> outputs 0 immediately; new hand sent from card 0 in full.
//  6. SKIP_EMPTY_EN defined, cards 1 and 16 = 00, others 35:
//     -> 15 transfers of 35; send_done; with the macro undefined -> 17 bytes including two 00.

Source files
------------

// File: rtl/poke_restore_tx.sv
// Maps a snapshot hand from sort encoding back to wire encoding and sends it one byte per transfer.
// Latency: first tx_valid 2 cycles after send_start; a full hand takes CARD_NUM transfer cycles plus 3.
// Backpressure: tx_data/tx_valid hold while tx_ready is low. Optional SKIP_EMPTY_EN drops 8'h00 slots.
module poke_restore_tx #(
  parameter int CARD_NUM = 17,
  parameter int CARD_W   = 8
) (
  input  logic                         sys_clk,
  input  logic                         sys_rst,
  input  logic                         send_start,
  input  logic [CARD_NUM*CARD_W-1:0]   arrange_poke,
  input  logic                         tx_ready,
  output logic [7:0]                   tx_data,
  output logic                         tx_valid,
  output logic                         busy,
  output logic                         send_done
);

  localparam int IDX_W = (CARD_NUM > 1) ? $clog2(CARD_NUM) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CARD_NUM - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SEND = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t                       state;
  logic [IDX_W-1:0]             idx;
  logic [CARD_NUM*CARD_W-1:0]   snapshot;

  logic [IDX_W-1:0]             nxt_idx;
  logic [7:0]                   cur_card;
  logic [7:0]                   nxt_card;
`ifdef SKIP_EMPTY_EN
  logic [IDX_W-1:0]             skip_idx;
`endif

  // Internal rank F/E go back to wire ranks 2/1; the suit nibble passes through.
  function automatic logic [7:0] restore(input logic [7:0] c);
    logic [7:0] r;
    case (c[7:4])
      4'hF:    r = {4'h2, c[3:0]};
      4'hE:    r = {4'h1, c[3:0]};
      default: r = c;
    endcase
    return r;
  endfunction

  function automatic logic [7:0] card_at(input logic [CARD_NUM*CARD_W-1:0] s,
                                         input logic [IDX_W-1:0]           i);
    return s[i*CARD_W +: 8];
  endfunction

  // Current and next card selection; nxt_idx saturates at the last slot so no index runs off the hand.
  always_comb begin
    nxt_idx  = (idx == LAST_IDX) ? idx : idx + 1'b1;
    cur_card = card_at(snapshot, idx);
    nxt_card = card_at(snapshot, nxt_idx);
`ifdef SKIP_EMPTY_EN
    // When the next slot is empty the following LOAD cycle is the skip cycle, so jump one further.
    skip_idx = (nxt_idx == LAST_IDX) ? nxt_idx : nxt_idx + 1'b1;
`endif
  end

  // Send sequencer: snapshot the hand, then stream restored cards under the valid/ready handshake.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state     <= IDLE;
      idx       <= '0;
      snapshot  <= '0;
      tx_data   <= 8'h00;
      tx_valid  <= 1'b0;
      busy      <= 1'b0;
      send_done <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (send_start) begin
            snapshot <= arrange_poke;
            idx      <= '0;
            busy     <= 1'b1;
            state    <= LOAD;
          end
        end

        LOAD: begin
`ifdef SKIP_EMPTY_EN
          if (cur_card == 8'h00) begin
            // Empty slot: one idle cycle, then either the next slot or the end of the hand.
            if (idx == LAST_IDX) begin
              send_done <= 1'b1;
              state     <= DONE;
            end else begin
              idx <= nxt_idx;
            end
          end else begin
            tx_data  <= restore(cur_card);
            tx_valid <= 1'b1;
            state    <= SEND;
          end
`else
          tx_data  <= restore(cur_card);
          tx_valid <= 1'b1;
          state    <= SEND;
`endif
        end

        SEND: begin
          if (tx_valid && tx_ready) begin
            if (idx == LAST_IDX) begin
              tx_valid  <= 1'b0;
              send_done <= 1'b1;
              state     <= DONE;
            end else begin
`ifdef SKIP_EMPTY_EN
              if (nxt_card == 8'h00) begin
                tx_valid <= 1'b0;
                idx      <= skip_idx;
                state    <= LOAD;
              end else begin
                idx     <= nxt_idx;
                tx_data <= restore(nxt_card);
              end
`else
              // Back-to-back transfer: present the next card on the same edge.
              idx     <= nxt_idx;
              tx_data <= restore(nxt_card);
`endif
            end
          end
        end

        DONE: begin
          send_done <= 1'b0;
          busy      <= 1'b0;
          state     <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_poke_restore_tx.sv
// Bench for poke_restore_tx: a hand-level model predicts the byte stream, a negedge monitor
// compares every transfer, checks holds during stalls and counts send_done pulses.
module tb_poke_restore_tx;

  localparam int CARD_NUM = 17;
  localparam int HW       = CARD_NUM * 8;
  localparam int LIMIT    = 400;

  logic          sys_clk;
  logic          sys_rst;
  logic          send_start;
  logic [HW-1:0] arrange_poke;
  logic          tx_ready;
  logic [7:0]    tx_data;
  logic          tx_valid;
  logic          busy;
  logic          send_done;

  int checks;
  int errors;
  int xfer_cnt;
  int done_cnt;
  bit prev_stall;
  logic [7:0] prev_data;
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];

  poke_restore_tx #(.CARD_NUM(CARD_NUM), .CARD_W(8)) dut (
    .sys_clk      (sys_clk),
    .sys_rst      (sys_rst),
    .send_start   (send_start),
    .arrange_poke (arrange_poke),
    .tx_ready     (tx_ready),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .busy         (busy),
    .send_done    (send_done)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Wire-encoding model: ranks F and E become 2 and 1, everything else unchanged.
  function automatic logic [7:0] model_restore(input logic [7:0] c);
    logic [3:0] rank;
    rank = c[7:4];
    if (rank == 4'd15)      rank = 4'd2;
    else if (rank == 4'd14) rank = 4'd1;
    return {rank, c[3:0]};
  endfunction

  function automatic logic [HW-1:0] hand_seq();
    logic [HW-1:0] h;
    for (int i = 0; i < CARD_NUM; i++) h[i*8 +: 8] = {4'(3 + i % 10), 4'h1};
    return h;
  endfunction

  function automatic logic [HW-1:0] hand_fe();
    logic [HW-1:0] h;
    for (int i = 0; i < CARD_NUM; i++) h[i*8 +: 8] = (i % 2 == 1) ? 8'hE7 : 8'hF0;
    h[7:0]   = 8'hF3;
    h[15:8]  = 8'hE2;
    h[23:16] = 8'hD4;
    h[31:24] = 8'hA1;
    return h;
  endfunction

  function automatic logic [HW-1:0] hand_gaps();
    logic [HW-1:0] h;
    for (int i = 0; i < CARD_NUM; i++) h[i*8 +: 8] = 8'h35;
    h[15:8]         = 8'h00;
    h[16*8 +: 8]    = 8'h00;
    return h;
  endfunction

  // Monitor: every accepted byte against the model queue, stalls must hold.
  always @(negedge sys_clk) begin
    if (sys_rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("hold_valid", {31'd0, tx_valid}, 32'd1);
        chk("hold_data", {24'd0, tx_data}, {24'd0, prev_data});
      end
      if (tx_valid && tx_ready) begin
        if (exp_q.size() == 0) chk("extra_byte", 32'd1, 32'd0);
        else chk("byte", {24'd0, tx_data}, {24'd0, exp_q.pop_front()});
        got_q.push_back(tx_data);
        xfer_cnt++;
      end
      if (send_done) begin
        done_cnt++;
        chk("busy_at_done", {31'd0, busy}, 32'd1);
      end
      prev_stall = tx_valid && !tx_ready;
      prev_data  = tx_data;
    end
  end

  // One send: rdy_mode 0 = always ready, 1 = ready 1-in-3; poke_at = cycle to re-pulse start
  // and change arrange_poke; rst_after = transfers after which reset is applied.
  task automatic run_send(input logic [HW-1:0] hand, input int rdy_mode,
                          input int poke_at, input int rst_after);
    int  cyc;
    int  exp_n;
    int  done_base;
    int  xfer_base;
    bit  aborted;
    logic [7:0] c;
    exp_q.delete();
    got_q.delete();
    for (int i = 0; i < CARD_NUM; i++) begin
      c = hand[i*8 +: 8];
`ifdef SKIP_EMPTY_EN
      if (c == 8'h00) continue;
`endif
      exp_q.push_back(model_restore(c));
    end
    exp_n     = exp_q.size();
    done_base = done_cnt;
    xfer_base = xfer_cnt;
    aborted   = 1'b0;
    arrange_poke = hand;
    tx_ready     = 1'b1;
    @(posedge sys_clk); #1;
    send_start = 1'b1;
    @(posedge sys_clk); #1;
    send_start = 1'b0;
    cyc = 1;
    while (cyc < LIMIT) begin
      if (cyc == 1) begin
        chk("busy_after_start", {31'd0, busy}, 32'd1);
        chk("valid_latency1", {31'd0, tx_valid}, 32'd0);
      end
      if (cyc == 2) chk("valid_latency2", {31'd0, tx_valid}, 32'd1);
      if (send_done) break;
      if (rst_after > 0 && (xfer_cnt - xfer_base) >= rst_after) begin
        sys_rst = 1'b1;
        #1;
        chk("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
        chk("rst_tx_data", {24'd0, tx_data}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_send_done", {31'd0, send_done}, 32'd0);
        chk("rst_xfer_count", xfer_cnt - xfer_base, rst_after);
        exp_q.delete();
        repeat (3) @(posedge sys_clk);
        #1;
        sys_rst = 1'b0;
        aborted = 1'b1;
        break;
      end
      tx_ready = (rdy_mode == 0) ? 1'b1 : (cyc % 3 == 0);
      if (poke_at > 0 && cyc == poke_at) begin
        send_start   = 1'b1;
        arrange_poke = ~hand;
      end else begin
        send_start = 1'b0;
      end
      @(posedge sys_clk); #1;
      cyc++;
    end
    send_start = 1'b0;
    tx_ready   = 1'b1;
    if (aborted) begin
      repeat (4) @(posedge sys_clk);
      #1;
      chk("after_rst_idle_valid", {31'd0, tx_valid}, 32'd0);
      chk("after_rst_no_done", done_cnt - done_base, 32'd0);
    end else if (cyc >= LIMIT) begin
      chk("done_timeout", 32'd0, 32'd1);
    end else begin
      if (rdy_mode == 0) chk("hand_cycles", cyc, CARD_NUM + 2);
      @(posedge sys_clk); #1;
      chk("busy_fall", {31'd0, busy}, 32'd0);
      chk("done_pulse_width", {31'd0, send_done}, 32'd0);
      repeat (3) @(posedge sys_clk);
      #1;
      chk("done_once", done_cnt - done_base, 32'd1);
      chk("byte_count", got_q.size(), exp_n);
      chk("queue_drained", exp_q.size(), 32'd0);
      chk("idle_valid", {31'd0, tx_valid}, 32'd0);
    end
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    xfer_cnt     = 0;
    done_cnt     = 0;
    prev_stall   = 1'b0;
    prev_data    = 8'h00;
    sys_rst      = 1'b1;
    send_start   = 1'b0;
    arrange_poke = '0;
    tx_ready     = 1'b1;
    #1;
    chk("reset_tx_valid", {31'd0, tx_valid}, 32'd0);
    chk("reset_tx_data", {24'd0, tx_data}, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_send_done", {31'd0, send_done}, 32'd0);
    repeat (2) @(posedge sys_clk);
    #1;
    sys_rst = 1'b0;

    // 1: plain ranks, always ready
    run_send(hand_seq(), 0, 0, 0);
    chk("t1_len", got_q.size(), 32'd17);
    if (got_q.size() == 17) begin
      chk("t1_first", {24'd0, got_q[0]}, 32'h31);
      chk("t1_tenth", {24'd0, got_q[10]}, 32'h31);
      chk("t1_last", {24'd0, got_q[16]}, 32'h91);
    end

    // 2: F/E restoration
    run_send(hand_fe(), 0, 0, 0);
    if (got_q.size() >= 5) begin
      chk("t2_b0", {24'd0, got_q[0]}, 32'h23);
      chk("t2_b1", {24'd0, got_q[1]}, 32'h12);
      chk("t2_b2", {24'd0, got_q[2]}, 32'hD4);
      chk("t2_b3", {24'd0, got_q[3]}, 32'hA1);
      chk("t2_b4", {24'd0, got_q[4]}, 32'h20);
    end else begin
      chk("t2_len", got_q.size(), 32'd17);
    end

    // 3: throttled ready
    run_send(hand_seq(), 1, 0, 0);

    // 4: restart attempt and hand change mid-send
    run_send(hand_fe(), 0, 5, 0);

    // 5: reset after the 5th transfer, then a full new send
    run_send(hand_fe(), 0, 0, 5);
    run_send(hand_seq(), 0, 0, 0);
    chk("t5_len", got_q.size(), 32'd17);
    if (got_q.size() > 0) chk("t5_first", {24'd0, got_q[0]}, 32'h31);

    // 6: empty slots
    run_send(hand_gaps(), 0, 0, 0);
`ifdef SKIP_EMPTY_EN
    chk("t6_len", got_q.size(), 32'd15);
    if (got_q.size() == 15) begin
      chk("t6_b1", {24'd0, got_q[1]}, 32'h35);
      chk("t6_b14", {24'd0, got_q[14]}, 32'h35);
    end
`else
    chk("t6_len", got_q.size(), 32'd17);
    if (got_q.size() == 17) begin
      chk("t6_b1", {24'd0, got_q[1]}, 32'h00);
      chk("t6_b2", {24'd0, got_q[2]}, 32'h35);
      chk("t6_b16", {24'd0, got_q[16]}, 32'h00);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
